// File: rtl/gate_truth_checker.sv
// Gate truth-table checker: sweeps {a,b}=00..11 PASSES times; build with FIRST_FAIL_CAPTURE_EN for first-fail capture.
// Latency: done 4*PASSES*(SETTLE_CYCLES+2) cycles after start is accepted; no backpressure, start ignored unless idle.
module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic [5:0]       gates_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [5:0]       fail_vec,
    output logic             ff_valid,
    output logic [1:0]       ff_ab,
    output logic [5:0]       ff_gates
);

    localparam int NVEC  = 4 * PASSES;
    localparam int IDX_W = $clog2(NVEC);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] CNT_INIT = (SETTLE_CYCLES > 0) ? SET_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d, b_q, b_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [5:0]       fail_q, fail_d;
    logic             pass_q, pass_d;
    logic [5:0]       expected;
    logic [5:0]       mism;
    logic             accept;

    // Ideal response of the gate block to the operands currently driven.
    always_comb begin
        expected = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), a_q | b_q, a_q & b_q};
        mism     = gates_in ^ expected;
    end

    assign accept = (state_q == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                cnt_d   = CNT_INIT;
                state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (mism != 6'b0) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + 1'b1;
                    end
                    fail_d = fail_q | mism;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    // Low two index bits are the {a,b} vector, so passes repeat 00..11.
                    idx_d   = idx_q + 1'b1;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic       ff_valid_q;
    logic [1:0] ff_ab_q;
    logic [5:0] ff_gates_q;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            ff_valid_q <= 1'b0;
            ff_ab_q    <= '0;
            ff_gates_q <= '0;
        end else if ((state_q == S_CHECK) && (mism != 6'b0) && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_ab_q    <= {a_q, b_q};
            ff_gates_q <= gates_in;
        end
    end

    assign ff_valid = ff_valid_q;
    assign ff_ab    = ff_ab_q;
    assign ff_gates = ff_gates_q;
`else
    assign ff_valid = 1'b0;
    assign ff_ab    = 2'b00;
    assign ff_gates = 6'b0;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (S=2,P=1,W=8 and S=0,P=4,W=2) driven by faultable gate models.
module tb_gate_truth_checker;

    localparam int S0 = 2, P0 = 1, W0 = 8;
    localparam int S1 = 0, P1 = 4, W1 = 2;

    typedef struct packed {
        logic       pass;
        logic [7:0] err;
        logic [5:0] fail;
        logic       ffv;
        logic [1:0] ffab;
        logic [5:0] ffg;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_s   [2];
    logic          start_s [2];
    logic [5:0]    inv_m   [2];
    logic [5:0]    s0_m    [2];
    logic [5:0]    s1_m    [2];

    logic          a0, b0, busy0, done0, pass0, ffv0;
    logic          a1, b1, busy1, done1, pass1, ffv1;
    logic [5:0]    g0, g1, fail0, fail1, ffg0, ffg1;
    logic [1:0]    ffab0, ffab1;
    logic [W0-1:0] err0;
    logic [W1-1:0] err1;

    logic          busy_m [2];
    logic          done_m [2];
    logic [1:0]    ab_m   [2];
    res_t          act    [2];
    res_t          last   [2];
    res_t          q0[$];
    res_t          q1[$];
    int            bc     [2];
    int            total = 0;
    int            bad   = 0;

    // Each gate as a 4-entry truth table indexed by {a,b}; order and,or,nand,nor,xor,xnor.
    function automatic logic [5:0] ideal(input logic [1:0] ab);
        logic [3:0] tt [6];
        logic [5:0] r;
        tt = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
        for (int g = 0; g < 6; g++) r[g] = tt[g][ab];
        return r;
    endfunction

    function automatic logic [5:0] faulty(input int i, input logic [1:0] ab);
        return ((ideal(ab) ^ inv_m[i]) & ~s0_m[i]) | s1_m[i];
    endfunction

    assign g0 = ((ideal({a0, b0}) ^ inv_m[0]) & ~s0_m[0]) | s1_m[0];
    assign g1 = ((ideal({a1, b1}) ^ inv_m[1]) & ~s1_m[1] & ~s0_m[1]) | s1_m[1];

    gate_truth_checker #(.SETTLE_CYCLES(S0), .PASSES(P0), .ERR_W(W0)) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .a_out(a0), .b_out(b0), .gates_in(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0),
        .ff_valid(ffv0), .ff_ab(ffab0), .ff_gates(ffg0));

    gate_truth_checker #(.SETTLE_CYCLES(S1), .PASSES(P1), .ERR_W(W1)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .a_out(a1), .b_out(b1), .gates_in(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1),
        .ff_valid(ffv1), .ff_ab(ffab1), .ff_gates(ffg1));

    always_comb begin
        busy_m[0] = busy0;
        busy_m[1] = busy1;
        done_m[0] = done0;
        done_m[1] = done1;
        ab_m[0]   = {a0, b0};
        ab_m[1]   = {a1, b1};
        act[0]    = {pass0, err0, fail0, ffv0, ffab0, ffg0};
        act[1]    = {pass1, 6'b0, err1, fail1, ffv1, ffab1, ffg1};
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Whole-run result from plain truth tables: per-vector mismatch, saturating count, sticky OR.
    function automatic res_t model(input int i);
        int         np   = (i == 0) ? P0 : P1;
        int         emax = (i == 0) ? (1 << W0) - 1 : (1 << W1) - 1;
        int         e    = 0;
        res_t       r    = '0;
        logic [1:0] ab;
        logic [5:0] obs, mism;
        for (int p = 0; p < np; p++) begin
            for (int v = 0; v < 4; v++) begin
                ab   = v[1:0];
                obs  = faulty(i, ab);
                mism = obs ^ ideal(ab);
                if (mism != 6'b0) begin
                    if (e < emax) e++;
                    r.fail |= mism;
`ifdef FIRST_FAIL_CAPTURE_EN
                    if (!r.ffv) begin
                        r.ffv  = 1'b1;
                        r.ffab = ab;
                        r.ffg  = obs;
                    end
`endif
                end
            end
        end
        r.err  = 8'(e);
        r.pass = (e == 0);
        return r;
    endfunction

    // Monitor: per-cycle operand sequence while busy, run length, results at done, held values when idle.
    always @(negedge clk) begin
        int   per, ncyc;
        res_t e;
        for (int i = 0; i < 2; i++) begin
            per  = (i == 0) ? S0 + 2 : S1 + 2;
            ncyc = (i == 0) ? 4 * P0 * (S0 + 2) : 4 * P1 * (S1 + 2);
            if (rst_s[i]) begin
                bc[i]   = 0;
                last[i] = '0;
            end else if (busy_m[i]) begin
                chk("busy_ab", 32'(ab_m[i]), 32'((bc[i] / per) % 4));
                chk("busy_and_done", 32'(done_m[i]), 32'd0);
                bc[i]++;
            end else if (done_m[i]) begin
                chk("run_len", bc[i], ncyc);
                bc[i] = 0;
                if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk("pass", 32'(act[i].pass), 32'(e.pass));
                    chk("err_count", 32'(act[i].err), 32'(e.err));
                    chk("fail_vec", 32'(act[i].fail), 32'(e.fail));
                    chk("ff_valid", 32'(act[i].ffv), 32'(e.ffv));
                    chk("ff_ab", 32'(act[i].ffab), 32'(e.ffab));
                    chk("ff_gates", 32'(act[i].ffg), 32'(e.ffg));
                    last[i] = e;
                end
            end else begin
                bc[i] = 0;
                chk("idle_ab", 32'(ab_m[i]), 32'd0);
                chk("idle_held", 32'(act[i]), 32'(last[i]));
            end
        end
    end

    task automatic set_fault(input int i, input logic [5:0] inv, input logic [5:0] s0, input logic [5:0] s1);
        inv_m[i] = inv;
        s0_m[i]  = s0;
        s1_m[i]  = s1;
    endtask

    task automatic push_exp(input int i);
        if (i == 0) q0.push_back(model(0));
        else        q1.push_back(model(1));
    endtask

    task automatic wait_done(input int i);
        bit seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done_m[i]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic run(input int i);
        push_exp(i);
        @(posedge clk); #1 start_s[i] = 1'b1;
        @(posedge clk); #1 start_s[i] = 1'b0;
        wait_done(i);
    endtask

    // start held through done: ignored in DONE, accepted again from the following IDLE cycle.
    task automatic run_held(input int i);
        push_exp(i);
        push_exp(i);
        @(posedge clk); #1 start_s[i] = 1'b1;
        wait_done(i);
        @(posedge clk);
        @(posedge clk); #1 start_s[i] = 1'b0;
        @(negedge clk);
        chk("restart_busy", 32'(busy_m[i]), 32'd1);
        wait_done(i);
    endtask

    task automatic run_random(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) set_fault(i, 6'b0, 6'b0, 6'b0);
            else set_fault(i, 6'($urandom & $urandom & $urandom), 6'($urandom & $urandom & $urandom),
                           6'($urandom & $urandom & $urandom));
            run(i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_s[i]   = 1'b1;
            start_s[i] = 1'b0;
            set_fault(i, 6'b0, 6'b0, 6'b0);
        end
        repeat (3) @(posedge clk);
        #1 rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 32'(busy_m[i]), 32'd0);
            chk("rst_done", 32'(done_m[i]), 32'd0);
            chk("rst_ab", 32'(ab_m[i]), 32'd0);
            chk("rst_results", 32'(act[i]), 32'd0);
        end
        fork
            begin
                run(0);
                set_fault(0, 6'b0, 6'b000100, 6'b0);
                run(0);
                set_fault(0, 6'b0, 6'b0, 6'b0);
                @(posedge clk); #1 start_s[0] = 1'b1;
                @(posedge clk); #1 start_s[0] = 1'b0;
                repeat (9) @(posedge clk);
                #1 rst_s[0] = 1'b1;
                @(posedge clk); #1 rst_s[0] = 1'b0;
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    chk("abort_no_done", 32'(done_m[0]), 32'd0);
                    chk("abort_idle", 32'(busy_m[0]), 32'd0);
                end
                run(0);
                run_held(0);
                run_random(0, 6);
            end
            begin
                set_fault(1, 6'h3f, 6'b0, 6'b0);
                run(1);
                set_fault(1, 6'b0, 6'b0, 6'b0);
                run(1);
                run_held(1);
                run_random(1, 6);
            end
        join
        repeat (5) @(posedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
